// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// op encodings, FSM states and the iteration counter width.
package mul_div_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// One shared 2*WIDTH accumulator serves both shift-add multiply and restoring divide.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hiWrEn,
    input  logic             loWrEn,
    input  logic [WIDTH-1:0] wrData,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sign_p_q, sign_p_d;
    logic               sign_r_q, sign_r_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               start_signed;
    logic               is_div;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic               div_borrow;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fix;

    assign start_signed = ~op[0];
    assign is_div       = op_q[1];
    assign acc_hi       = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo       = acc_q[WIDTH-1:0];

    // Multiply: add multiplicand into the upper half when the current multiplier LSB is set,
    // then shift the whole accumulator right (carry lands in the top bit).
    assign mul_sum = {1'b0, acc_hi} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    // Divide: partial remainder in the upper half, quotient bits shift into the lower half,
    // dividend bits feed in MSB-first from a_q. Extra headroom bit exposes the borrow.
    assign div_trial  = {1'b0, acc_hi, a_q[WIDTH-1]} - {2'b00, b_q};
    assign div_borrow = div_trial[WIDTH+1];
    assign rem_next   = div_borrow ? {acc_hi[WIDTH-2:0], a_q[WIDTH-1]} : div_trial[WIDTH-1:0];

    assign prod_fix = sign_p_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sign_p_d = sign_p_q;
        sign_r_d = sign_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    a_d      = (start_signed && opA[WIDTH-1]) ? (~opA + 1'b1) : opA;
                    b_d      = (start_signed && opB[WIDTH-1]) ? (~opB + 1'b1) : opB;
                    sign_p_d = start_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                    sign_r_d = start_signed & opA[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    state_d  = CALC;
                end else begin
                    if (hiWrEn) hi_d = wrData;
                    if (loWrEn) lo_d = wrData;
                end
            end
            CALC: begin
                if (is_div) begin
                    acc_d = {rem_next, acc_lo[WIDTH-2:0], ~div_borrow};
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_lo[WIDTH-1:1]};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = FIXUP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIXUP: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (is_div) begin
                    // b_q is never shifted on divide, so it still holds the divisor magnitude.
                    if (b_q == '0) begin
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = sign_p_q ? (~acc_lo + 1'b1) : acc_lo;
                        hi_d = sign_r_q ? (~acc_hi + 1'b1) : acc_hi;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sign_p_q <= 1'b0;
            sign_r_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sign_p_q <= sign_p_d;
            sign_r_q <= sign_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign divByZero = dbz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: products, quotients, edge cases,
// control interactions and asynchronous reset mid-operation.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA, opB;
    logic        hiWrEn, loWrEn;
    logic [31:0] wrData;
    logic        busy, done, divByZero;
    logic [31:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
        .hiWrEn(hiWrEn), .loWrEn(loWrEn), .wrData(wrData),
        .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulses start across one rising edge (edge N); returns #1 after that edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic lo_wr);
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b;
        loWrEn = lo_wr; wrData = 32'h0000_FFFF;
        @(posedge clk); #1;
        start = 1'b0; loWrEn = 1'b0;
        op = ~o; opA = ~a; opB = ~b;   // later operand changes must have no effect
    endtask

    // Runs one operation and checks latency, busy, result and flags.
    // inject=1: retry start and an MTHI write while busy.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_dbz, input int inject, input logic lo_wr);
        int  k;
        bit  busy_ok;
        issue(o, a, b, lo_wr);
        busy_ok = (busy === 1'b1);
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            start = 1'b0; hiWrEn = 1'b0;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 0;
            if (inject == 1 && k == 5) begin
                start = 1'b1; op = OP_MULTU; opA = 32'd2; opB = 32'd3;
            end
            if (inject == 1 && k == 10) begin
                hiWrEn = 1'b1; wrData = 32'h1234;
            end
        end
        chk({tag, " done"},    {63'd0, done}, 64'd1);
        chk({tag, " latency"}, 64'(k), 64'd33);
        chk({tag, " busy"},    {63'd0, busy_ok}, 64'd1);
        chk({tag, " hi/lo"},   {hi, lo}, {e_hi, e_lo});
        chk({tag, " dbz"},     {63'd0, divByZero}, {63'd0, e_dbz});
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {62'd0, done, divByZero}, 64'd0);
    endtask

    initial begin
        bit stray;
        rst = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
        hiWrEn = 1'b0; loWrEn = 1'b0; wrData = '0;
        #1;
        chk("reset outputs", {hi, lo}, 64'd0);
        chk("reset flags", {61'd0, busy, done, divByZero}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op("MULTU max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 0);
        run_op("MULT -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 0);
        run_op("MULT min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 0, 0);
        run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
        run_op("DIVU 7/2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0, 0, 0);
        run_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 0, 0);
        run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0, 0);

        // Preload HI/LO in one IDLE cycle, then divide by zero must leave them intact.
        @(negedge clk);
        hiWrEn = 1'b1; loWrEn = 1'b1; wrData = 32'hAAAA;
        @(negedge clk);
        chk("MT both", {hi, lo}, {32'hAAAA, 32'hAAAA});
        loWrEn = 1'b1; hiWrEn = 1'b0; wrData = 32'h5555;
        @(negedge clk);
        loWrEn = 1'b0;
        chk("MTLO preload", {hi, lo}, {32'hAAAA, 32'h5555});
        run_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 32'hAAAA, 32'h5555, 1, 0, 0);

        run_op("busy ignore", OP_MULTU, 32'd10, 32'd10, 32'h0, 32'd100, 0, 1, 0);
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) stray = 1;
        end
        chk("no queued start", {63'd0, stray}, 64'd0);

        @(negedge clk);
        hiWrEn = 1'b1; wrData = 32'h1234;
        @(posedge clk); #1;
        hiWrEn = 1'b0;
        chk("MTHI idle", {hi, lo}, {32'h1234, 32'd100});

        run_op("start+MTLO", OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 0, 0, 1);

        // Abort a DIVU at the 10th CALC cycle.
        issue(OP_DIVU, 32'd100, 32'd7, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst mid hi/lo", {hi, lo}, 64'd0);
        chk("rst mid flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) stray = 1;
        end
        chk("no done after rst", {63'd0, stray}, 64'd0);

        run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
